// File: rtl/supervisor_pkg.sv
// supervisor_pkg: shared state encoding and field widths for the sensor supervisor
package supervisor_pkg;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_MONITOR = 3'd1;
    localparam logic [2:0] ST_TRIP    = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;
    localparam int RC_W = 4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_MONITOR = ST_MONITOR,
        S_TRIP    = ST_TRIP,
        S_WAIT    = ST_WAIT,
        S_LOCKOUT = ST_LOCKOUT
    } state_t;
endpackage

// File: rtl/supervisor_channel.sv
// supervisor_channel: one channel's debounced fault detect, relay trip, timed retry and lockout
module supervisor_channel
    import supervisor_pkg::*;
#(
    parameter int SEN_W      = 16,
    parameter int SEN_REF    = 350,
    parameter int THRESHOLD  = 100,
    parameter int DEBOUNCE   = 3,
    parameter int MAX_RETRY  = 3,
    parameter int WAIT_TICKS = 312
) (
    input  logic             clk_16ms,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ack,
    input  logic [SEN_W-1:0] sen,
    output logic             relay,
    output logic             lockout,
    output logic             lock_nxt,
    output logic [RC_W-1:0]  retry_cnt
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(WAIT_TICKS + 1);

    state_t st, st_n;
    logic [DW-1:0] deb, deb_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [RC_W-1:0] rc_n;
    logic [SEN_W-1:0] diff;
    logic fail;

    assign diff = sen > SEN_W'(SEN_REF) ? sen - SEN_W'(SEN_REF) : SEN_W'(SEN_REF) - sen;
    assign fail = diff > SEN_W'(THRESHOLD);

    always_comb begin
        st_n  = st;
        deb_n = deb;
        tmr_n = tmr;
        rc_n  = retry_cnt;
        case (st)
            S_IDLE: st_n = en ? S_MONITOR : S_IDLE;
            S_MONITOR: begin
                deb_n = fail ? deb + 1'b1 : '0;
                tmr_n = fail ? '0 : tmr + 1'b1;
                if (fail && deb_n == DW'(DEBOUNCE)) st_n = S_TRIP;
                // a full healthy run forgives earlier trips
                if (!fail && tmr_n == TW'(WAIT_TICKS)) begin
                    tmr_n = '0;
                    rc_n  = '0;
                end
            end
            S_TRIP: begin
                rc_n  = retry_cnt + 1'b1;
                tmr_n = '0;
                st_n  = S_WAIT;
            end
            S_WAIT: begin
                tmr_n = tmr + 1'b1;
                if (tmr == TW'(WAIT_TICKS - 1)) begin
                    tmr_n = '0;
                    deb_n = '0;
                    st_n  = retry_cnt == RC_W'(MAX_RETRY) ? S_LOCKOUT : S_MONITOR;
                end
            end
            S_LOCKOUT: st_n = ack ? S_IDLE : S_LOCKOUT;
            default: st_n = S_IDLE;
        endcase
        if (!en && st inside {S_MONITOR, S_TRIP, S_WAIT}) st_n = S_IDLE;
        // entering or sitting in IDLE wipes all per-channel history
        if (st_n == S_IDLE) begin
            deb_n = '0;
            tmr_n = '0;
            rc_n  = '0;
        end
        lock_nxt = st_n == S_LOCKOUT;
    end

    always_ff @(posedge clk_16ms or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            deb       <= '0;
            tmr       <= '0;
            retry_cnt <= '0;
            relay     <= 1'b0;
            lockout   <= 1'b0;
        end else begin
            st        <= st_n;
            deb       <= deb_n;
            tmr       <= tmr_n;
            retry_cnt <= rc_n;
            relay     <= st_n inside {S_TRIP, S_WAIT, S_LOCKOUT};
            lockout   <= lock_nxt;
        end
    end
endmodule

// File: rtl/multi_channel_sensor_supervisor.sv
// multi_channel_sensor_supervisor: N_CH independent channel supervisors plus a registered alarm
module multi_channel_sensor_supervisor
    import supervisor_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int SEN_W      = 16,
    parameter int SEN_REF    = 350,
    parameter int THRESHOLD  = 100,
    parameter int DEBOUNCE   = 3,
    parameter int MAX_RETRY  = 3,
    parameter int WAIT_TICKS = 312
) (
    input  logic                  clk_16ms,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH-1:0]       ack,
    input  logic [N_CH*SEN_W-1:0] sen,
    output logic [N_CH-1:0]       relay_out,
    output logic [N_CH-1:0]       lockout,
    output logic                  alarm,
    output logic [N_CH*RC_W-1:0]  retry_cnt
);
    logic [N_CH-1:0] lock_nxt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        supervisor_channel #(
            .SEN_W(SEN_W), .SEN_REF(SEN_REF), .THRESHOLD(THRESHOLD),
            .DEBOUNCE(DEBOUNCE), .MAX_RETRY(MAX_RETRY), .WAIT_TICKS(WAIT_TICKS)
        ) u_ch (
            .clk_16ms (clk_16ms),
            .rst_n    (rst_n),
            .en       (ch_en[i]),
            .ack      (ack[i]),
            .sen      (sen[i*SEN_W +: SEN_W]),
            .relay    (relay_out[i]),
            .lockout  (lockout[i]),
            .lock_nxt (lock_nxt[i]),
            .retry_cnt(retry_cnt[i*RC_W +: RC_W])
        );
    end

    always_ff @(posedge clk_16ms or negedge rst_n) begin
        if (!rst_n) alarm <= 1'b0;
        else alarm <= |lock_nxt;
    end
endmodule
